// File: rtl/slc3_pkg.sv
// Shared SLC-3 types and condition-code helpers used by the writeback stage and register file.
package slc3_pkg;

  typedef logic [2:0]  reg_idx_t;
  typedef logic [15:0] word_t;

  localparam int NZP_N = 2;
  localparam int NZP_Z = 1;
  localparam int NZP_P = 0;
  localparam logic [2:0] NZP_RESET = 3'b010;

  typedef enum logic {
    WB_EMPTY = 1'b0,
    WB_FULL  = 1'b1
  } wb_state_t;

  // Exactly one bit set: negative, zero or positive.
  function automatic logic [2:0] calc_nzp(input word_t w);
    logic [2:0] n;
    n        = '0;
    n[NZP_N] = w[15];
    n[NZP_Z] = (w == '0);
    n[NZP_P] = !w[15] && (w != '0);
    return n;
  endfunction

endpackage

// File: rtl/slc3_regfile.sv
// 8x16 general register file: one synchronous write port, two combinational read ports,
// asynchronous active-low clear.
module slc3_regfile
  import slc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8,
  parameter int IDX_W  = $clog2(NREGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [IDX_W-1:0]  rd1_idx,
  output logic [DATA_W-1:0] rd1_data,
  input  logic [IDX_W-1:0]  rd2_idx,
  output logic [DATA_W-1:0] rd2_data
);

  logic [DATA_W-1:0] regs [NREGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[wr_idx] <= wr_data;
    end
  end

  // Reads return the pre-write value during the write cycle.
  assign rd1_data = regs[rd1_idx];
  assign rd2_data = regs[rd2_idx];

endmodule

// File: rtl/alu_writeback.sv
// SLC-3 writeback stage: one-entry result buffer committing to the register file, NZP and BEN.
// Optional read bypass of the buffered result is enabled by defining ALU_WRITEBACK_BYPASS_EN.
module alu_writeback
  import slc3_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [DATA_W-1:0] Result,
  input  reg_idx_t          DR,
  input  logic              LD_REG,
  input  logic              LD_CC,
  input  logic              Hold,
  input  reg_idx_t          SR1,
  input  reg_idx_t          SR2,
  output logic [DATA_W-1:0] SR1_Out,
  output logic [DATA_W-1:0] SR2_Out,
  output logic [2:0]        NZP,
  input  logic              LD_BEN,
  input  reg_idx_t          IR_11_9,
  output logic              BEN
);

  // Handshake: a result transfers on a rising edge where In_Valid and In_Ready are both high;
  // In_Ready depends only on stage occupancy and Hold, never on In_Valid.

  wb_state_t         state;
  logic              wb_valid;
  logic [DATA_W-1:0] wb_data;
  reg_idx_t          wb_dr;
  logic              wb_ld_reg;
  logic              wb_ld_cc;
  logic [2:0]        nzp_q;
  logic              ben_q;

  logic              accept;
  logic              commit;
  logic [DATA_W-1:0] rd1_data;
  logic [DATA_W-1:0] rd2_data;

  assign wb_valid = (state == WB_FULL);
  assign In_Ready = !wb_valid || !Hold;
  assign accept   = In_Valid && In_Ready;
  assign commit   = wb_valid && !Hold;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= WB_EMPTY;
      wb_data   <= '0;
      wb_dr     <= '0;
      wb_ld_reg <= 1'b0;
      wb_ld_cc  <= 1'b0;
      nzp_q     <= NZP_RESET;
      ben_q     <= 1'b0;
    end else begin
      case (state)
        WB_EMPTY: if (accept) state <= WB_FULL;
        WB_FULL:  if (commit && !accept) state <= WB_EMPTY;
        default:  state <= WB_EMPTY;
      endcase

      if (accept) begin
        wb_data   <= Result;
        wb_dr     <= DR;
        wb_ld_reg <= LD_REG;
        wb_ld_cc  <= LD_CC;
      end

      if (commit && wb_ld_cc) begin
        nzp_q <= calc_nzp(wb_data);
      end

      // Samples the registered NZP, so a same-edge LD_CC commit is not seen here.
      if (LD_BEN) begin
        ben_q <= |(IR_11_9 & nzp_q);
      end
    end
  end

  slc3_regfile #(
    .DATA_W (DATA_W),
    .NREGS  (NREGS),
    .IDX_W  ($bits(reg_idx_t))
  ) u_regfile (
    .clk      (Clk),
    .rst_n    (Reset_n),
    .we       (commit && wb_ld_reg),
    .wr_idx   (wb_dr),
    .wr_data  (wb_data),
    .rd1_idx  (SR1),
    .rd1_data (rd1_data),
    .rd2_idx  (SR2),
    .rd2_data (rd2_data)
  );

`ifdef ALU_WRITEBACK_BYPASS_EN
  assign SR1_Out = (wb_valid && wb_ld_reg && (SR1 == wb_dr)) ? wb_data : rd1_data;
  assign SR2_Out = (wb_valid && wb_ld_reg && (SR2 == wb_dr)) ? wb_data : rd2_data;
`else
  assign SR1_Out = rd1_data;
  assign SR2_Out = rd2_data;
`endif

  assign NZP = nzp_q;
  assign BEN = ben_q;

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Writeback stage directly downstream of the SLC-3 datapath ALU.
- Buffers one 16-bit ALU result per handshake and commits it to the 8x16 general register file. Updates the NZP condition codes and computes BEN.
- The register file's two combinational read ports feed the ALU operand inputs, closing the ALU -> writeback -> operand loop.

Parameters:
- DATA_W, 16, datapath word width.
- NREGS, 8, number of general registers; index width is clog2(NREGS).

Ports:
- Clk  in  1  system clock, rising-edge.
- Reset_n  in  1  asynchronous, active-low reset.
- In_Valid  in  1  result presented this cycle.
- In_Ready  out  1  stage can accept a result this cycle.
- Result  in  DATA_W  ALU output to be written back.
- DR  in  3  destination register index.
- LD_REG  in  1  result updates DR when committed.
- LD_CC  in  1  result updates NZP when committed.
- Hold  in  1  freeze commit (memory wait / debug stall).
- SR1  in  3  read index, port 1.
- SR2  in  3  read index, port 2.
- SR1_Out  out  DATA_W  register SR1 contents; drives ALU A_In.
- SR2_Out  out  DATA_W  register SR2 contents; feeds SR2MUX -> ALU B_In.
- NZP  out  3  condition codes {N,Z,P}.
- LD_BEN  in  1  latch branch-enable.
- IR_11_9  in  3  branch condition mask from the IR.
- BEN  out  1  branch-enable flag.

Behaviour:
- Reset_n low, asynchronous:
  - all registers R0..R7 = 16'h0000;
  - stage EMPTY, wb_valid = 0;
  - NZP = 3'b010;
  - BEN = 0.
- Reset releases synchronously in effect: the first capture can occur on the first rising edge with Reset_n high.
- Stage FSM has two states, EMPTY and FULL (held as wb_valid).
- In_Ready = !wb_valid | !Hold. It is combinational from state and Hold only, never from In_Valid.
- Accept: In_Valid & In_Ready at a rising edge.
  - Captures Result, DR, LD_REG, LD_CC into stage registers.
  - Next state is FULL.
- Commit: FULL & !Hold at a rising edge.
  - If wb_ld_reg: R[wb_dr] <= wb_data.
  - If wb_ld_cc: NZP <= {wb_data[15], wb_data==0, !wb_data[15] & wb_data!=0}. Exactly one bit is set.
  - Next state is EMPTY unless an accept occurs in the same cycle.
- Latency: a result accepted at edge k is visible in the register array and NZP after edge k+1, assuming Hold is low at k+1.
- Simultaneous commit and accept in FULL with !Hold:
  - the old entry commits;
  - the new entry is captured;
  - state stays FULL;
  - sustained throughput is 1 result per cycle.
- Hold high in FULL:
  - nothing commits;
  - In_Ready = 0;
  - stage contents are stable.
- Hold high in EMPTY: accept still permitted. Hold does not block capture into an empty stage.
- In_Valid with LD_REG=0 and LD_CC=0: accepted and committed with no architectural effect.
- Reads: SR1_Out/SR2_Out = R[SR1]/R[SR2], combinational.
  - Without bypass, a read in the commit cycle returns the pre-commit value.
  - Both ports may address the same register.
- BEN: on a rising edge with LD_BEN, BEN <= |(IR_11_9 & NZP), using the registered NZP.
  - A commit with LD_CC in the same cycle does not affect that BEN; the old NZP is used.
  - BEN holds its value otherwise.
- Reset asserted mid-operation: any pending FULL entry is discarded and not committed.

Optional Feature:
- Macro: ALU_WRITEBACK_BYPASS_EN.
- Defined: when FULL & wb_ld_reg & SRx==wb_dr, SRx_Out returns wb_data instead of R[SRx]. Applies per port, independent of Hold.
- Defined: NZP output and BEN are not bypassed.
- Undefined: reads come from the array only. Software and the control FSM must allow one cycle between dependent instructions.

Decomposition:
- Shared package slc3_pkg holds:
  - reg_idx_t (logic [2:0]);
  - word_t (logic [15:0]);
  - NZP bit-position constants NZP_N=2, NZP_Z=1, NZP_P=0;
  - NZP_RESET = 3'b010;
  - function calc_nzp(word_t) returning logic [2:0].
- One sub-module: slc3_regfile (8x16 array, one write port, two async read ports, async active-low clear).
- Stage register, NZP register and BEN logic stay in alu_writeback.

Test Plan:
- Reset, then read all 8 registers via SR1/SR2 -> all 16'h0000; NZP=3'b010; BEN=0; In_Ready=1.
- Accept Result=16'h8001, DR=3, LD_REG=1, LD_CC=1; Hold=0 -> after the next edge R3=16'h8001 and NZP=3'b100. The cycle before, SR1=3 reads 0 without the bypass macro and 16'h8001 with it.
- Back-to-back accepts of 16'h0000 to R1 then 16'h0005 to R2 on consecutive cycles -> In_Ready stays 1; R1=0 then R2=5; final NZP=3'b001.
- FULL with Hold=1 for 3 cycles -> In_Ready=0; R array and NZP unchanged. Drop Hold -> commit on the next edge.
- NZP=3'b100, IR_11_9=3'b011, LD_BEN=1 -> BEN=0. Same edge also commits LD_CC with 16'h0007 -> BEN stays 0 and NZP becomes 3'b001.
- Assert Reset_n low while FULL holding 16'h1234 for R7 -> R7=0 after reset and never written; state EMPTY.
